uart_bmrd_16bit: RTL and testbench

//  Readback counterpart of the UART program downloader: reads a block of 16-bit words from

---
 rtl/uart_bmrd_16bit_if.sv | 25 ++
 rtl/uart_bmrd_16bit.sv | 164 ++++++++++++++++
 tb/tb_uart_bmrd_16bit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bmrd_16bit_if.sv
// Host/memory-side bundle for the UART block-memory readback streamer.
// The master modport drives requests and memory data; the slave modport is the streamer.
interface uart_bmrd_16bit_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start_i;
  logic [ADDR_W-1:0] base_adr_i;
  logic [ADDR_W-1:0] len_i;
  logic              mem_ren_o;
  logic [ADDR_W-1:0] mem_adr_o;
  logic [15:0]       mem_dat_i;
  logic              busy_o;
  logic              done_o;
  logic              uart_tx_o;

  modport master (
    output start_i, base_adr_i, len_i, mem_dat_i,
    input  mem_ren_o, mem_adr_o, busy_o, done_o, uart_tx_o
  );

  modport slave (
    input  start_i, base_adr_i, len_i, mem_dat_i,
    output mem_ren_o, mem_adr_o, busy_o, done_o, uart_tx_o
  );
endinterface

// File: rtl/uart_bmrd_16bit.sv
// Streams len 16-bit words from block memory out over UART 8N1, low byte first.
// Optional UPD_CHECKSUM_EN appends a 16-bit running-sum trailer before completion.
module uart_bmrd_16bit #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic               clk,
  input  logic               rst,
  uart_bmrd_16bit_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_TXLO,
    S_TXHI,
`ifdef UPD_CHECKSUM_EN
    S_CKLO,
    S_CKHI,
`endif
    S_FIN
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       word;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        bitn;
  logic              mem_ren;
  logic [ADDR_W-1:0] mem_adr;
  logic              busy;
  logic              done;
  logic              tx;
  logic [7:0]        cur_byte;
`ifdef UPD_CHECKSUM_EN
  logic [15:0]       sum;
`endif

  assign bus.mem_ren_o = mem_ren;
  assign bus.mem_adr_o = mem_adr;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.uart_tx_o = tx;

  always_comb begin
    cur_byte = word[7:0];
    case (state)
      S_TXHI:  cur_byte = word[15:8];
`ifdef UPD_CHECKSUM_EN
      S_CKLO:  cur_byte = sum[7:0];
      S_CKHI:  cur_byte = sum[15:8];
`endif
      default: cur_byte = word[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      base    <= '0;
      len     <= '0;
      idx     <= '0;
      word    <= '0;
      cnt     <= '0;
      bitn    <= '0;
      mem_ren <= 1'b0;
      mem_adr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tx      <= 1'b1;
`ifdef UPD_CHECKSUM_EN
      sum     <= '0;
`endif
    end else begin
      mem_ren <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start_i) begin
            base <= bus.base_adr_i;
            len  <= bus.len_i;
            idx  <= '0;
`ifdef UPD_CHECKSUM_EN
            sum  <= '0;
`endif
            if (bus.len_i == '0) begin
`ifdef UPD_CHECKSUM_EN
              state <= S_CKLO;
              busy  <= 1'b1;
              tx    <= 1'b0;
              cnt   <= '0;
              bitn  <= '0;
`else
              state <= S_FIN;
              done  <= 1'b1;
`endif
            end else begin
              state   <= S_RD;
              busy    <= 1'b1;
              mem_ren <= 1'b1;
              mem_adr <= bus.base_adr_i;
            end
          end
        end
        S_RD: state <= S_CAP;
        S_CAP: begin
          word  <= bus.mem_dat_i;
`ifdef UPD_CHECKSUM_EN
          sum   <= sum + bus.mem_dat_i;
`endif
          tx    <= 1'b0;
          cnt   <= '0;
          bitn  <= '0;
          state <= S_TXLO;
        end
        S_FIN: state <= S_IDLE;
        S_TXLO, S_TXHI
`ifdef UPD_CHECKSUM_EN
        , S_CKLO, S_CKHI
`endif
        : begin
          if (cnt != CNT_W'(CLKS_PER_BIT - 1)) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            // bitn is the bit now on the line; the next one is data bit bitn, or stop after D7
            if (bitn != 4'd9) begin
              bitn <= bitn + 4'd1;
              tx   <= (bitn == 4'd8) ? 1'b1 : cur_byte[bitn[2:0]];
            end else if (state == S_TXLO) begin
              state <= S_TXHI;
              tx    <= 1'b0;
              bitn  <= '0;
            end else if (state == S_TXHI && (idx + ADDR_W'(1)) != len) begin
              idx     <= idx + ADDR_W'(1);
              mem_adr <= base + idx + ADDR_W'(1);
              mem_ren <= 1'b1;
              state   <= S_RD;
`ifdef UPD_CHECKSUM_EN
            end else if (state == S_TXHI) begin
              state <= S_CKLO;
              tx    <= 1'b0;
              bitn  <= '0;
            end else if (state == S_CKLO) begin
              state <= S_CKHI;
              tx    <= 1'b0;
              bitn  <= '0;
`endif
            end else begin
              state <= S_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bmrd_16bit.sv
// Directed bench for uart_bmrd_16bit: bench-side memory model and UART receiver,
// hand-computed byte streams and cycle timings at CLKS_PER_BIT=4.
module tb_uart_bmrd_16bit;
  localparam int CPB      = 4;
  localparam int FRAME    = 10 * CPB;
  localparam int PER_WORD = 2 + 2 * FRAME;
`ifdef UPD_CHECKSUM_EN
  localparam int CK_BYTES = 2;
`else
  localparam int CK_BYTES = 0;
`endif
  localparam int CK_CYC = CK_BYTES * FRAME;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [15:0] mem [0:65535];

  logic [7:0]  rx_q[$];
  int          rx_t[$];
  logic [15:0] ren_q[$];
  int          frame_err = 0;

  uart_bmrd_16bit_if #(.ADDR_W(16)) bus ();

  uart_bmrd_16bit #(.ADDR_W(16), .CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Block memory: data valid the cycle after a read enable.
  always @(posedge clk) begin
    if (bus.mem_ren_o === 1'b1) begin
      bus.mem_dat_i <= mem[bus.mem_adr_o];
      if (!rst) ren_q.push_back(bus.mem_adr_o);
    end
  end

  // UART receiver sampling each bit at its middle cycle.
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (bus.uart_tx_o === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt = 0;
        rx_t.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        if (rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) rx_byte[rx_cnt / CPB - 1] = bus.uart_tx_o;
        if (rx_cnt / CPB == 9) begin
          if (bus.uart_tx_o !== 1'b1) frame_err++;
          rx_q.push_back(rx_byte);
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic clear_logs();
    rx_q.delete();
    rx_t.delete();
    ren_q.delete();
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] l, output int t);
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.base_adr_i = b;
    bus.len_i = l;
    t = cyc;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.uart_tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", bus.uart_tx_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done_o); end
    n_cmp++; if (bus.mem_ren_o !== 1'b0) begin n_fail++; $display("FAIL reset_ren got %b want 0", bus.mem_ren_o); end
    n_cmp++; if (bus.mem_adr_o !== 16'h0000) begin n_fail++; $display("FAIL reset_adr got %h want 0000", bus.mem_adr_o); end
  endtask

  task automatic test_single_word();
    int t, td;
    clear_logs();
    mem[16'h0010] = 16'hA55A;
    do_start(16'h0010, 16'h0001, t);
    @(negedge clk);
    n_cmp++; if (bus.mem_ren_o !== 1'b1) begin n_fail++; $display("FAIL single_ren got %b want 1", bus.mem_ren_o); end
    n_cmp++; if (bus.mem_adr_o !== 16'h0010) begin n_fail++; $display("FAIL single_adr got %h want 0010", bus.mem_adr_o); end
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", bus.busy_o); end
    @(negedge clk);
    n_cmp++; if (bus.mem_ren_o !== 1'b0) begin n_fail++; $display("FAIL single_ren_pulse got %b want 0", bus.mem_ren_o); end
    wait_done(1000, td);
    n_cmp++; if (td != t + 1 + PER_WORD + CK_CYC) begin n_fail++; $display("FAIL single_done_time got %0d want %0d", td - t, 1 + PER_WORD + CK_CYC); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done got %b want 0", bus.busy_o); end
    @(negedge clk);
    n_cmp++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL single_done_width got %b want 0", bus.done_o); end
    n_cmp++; if (rx_q.size() != 2 + CK_BYTES) begin n_fail++; $display("FAIL single_nbytes got %0d want %0d", rx_q.size(), 2 + CK_BYTES); end
    if (rx_q.size() >= 2) begin
      n_cmp++; if (rx_q[0] !== 8'h5A) begin n_fail++; $display("FAIL single_byte0 got %h want 5a", rx_q[0]); end
      n_cmp++; if (rx_q[1] !== 8'hA5) begin n_fail++; $display("FAIL single_byte1 got %h want a5", rx_q[1]); end
      n_cmp++; if (rx_t[0] != t + 3) begin n_fail++; $display("FAIL single_start_latency got %0d want 3", rx_t[0] - t); end
      n_cmp++; if (rx_t[1] != rx_t[0] + FRAME) begin n_fail++; $display("FAIL single_b2b_gap got %0d want %0d", rx_t[1] - rx_t[0], FRAME); end
    end
  endtask

  task automatic test_multi_word();
    int t, td;
    logic [7:0] exp [0:5];
    exp[0] = 8'h01; exp[1] = 8'h00; exp[2] = 8'h03; exp[3] = 8'h02; exp[4] = 8'hFF; exp[5] = 8'hFF;
    clear_logs();
    mem[16'h0000] = 16'h0001;
    mem[16'h0001] = 16'h0203;
    mem[16'h0002] = 16'hFFFF;
    do_start(16'h0000, 16'h0003, t);
    repeat (30) @(posedge clk);
    #1;
    bus.start_i = 1'b1; bus.base_adr_i = 16'h0100; bus.len_i = 16'h0005;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_done(2000, td);
    n_cmp++; if (td != t + 1 + 3 * PER_WORD + CK_CYC) begin n_fail++; $display("FAIL multi_done_time got %0d want %0d", td - t, 1 + 3 * PER_WORD + CK_CYC); end
    n_cmp++; if (rx_q.size() != 6 + CK_BYTES) begin n_fail++; $display("FAIL multi_nbytes got %0d want %0d", rx_q.size(), 6 + CK_BYTES); end
    n_cmp++; if (ren_q.size() != 3) begin n_fail++; $display("FAIL multi_nreads got %0d want 3", ren_q.size()); end
    if (ren_q.size() == 3) begin
      n_cmp++; if (ren_q[2] !== 16'h0002) begin n_fail++; $display("FAIL multi_last_adr got %h want 0002", ren_q[2]); end
    end
    if (rx_q.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL multi_byte%0d got %h want %h", i, rx_q[i], exp[i]); end
      end
      n_cmp++; if (rx_t[2] - rx_t[1] != FRAME + 2) begin n_fail++; $display("FAIL multi_word_gap got %0d want %0d", rx_t[2] - rx_t[1], FRAME + 2); end
      n_cmp++; if (rx_t[4] - rx_t[3] != FRAME + 2) begin n_fail++; $display("FAIL multi_word_gap2 got %0d want %0d", rx_t[4] - rx_t[3], FRAME + 2); end
    end
    n_cmp++; if (frame_err != 0) begin n_fail++; $display("FAIL multi_stop_bits got %0d want 0", frame_err); end
  endtask

  task automatic test_addr_wrap_and_empty();
    int t, td;
    logic [7:0] exp [0:3];
    exp[0] = 8'h34; exp[1] = 8'h12; exp[2] = 8'h78; exp[3] = 8'h56;
    clear_logs();
    mem[16'hFFFF] = 16'h1234;
    mem[16'h0000] = 16'h5678;
    do_start(16'hFFFF, 16'h0002, t);
    wait_done(2000, td);
    n_cmp++; if (td != t + 1 + 2 * PER_WORD + CK_CYC) begin n_fail++; $display("FAIL wrap_done_time got %0d want %0d", td - t, 1 + 2 * PER_WORD + CK_CYC); end
    n_cmp++; if (ren_q.size() != 2) begin n_fail++; $display("FAIL wrap_nreads got %0d want 2", ren_q.size()); end
    if (ren_q.size() == 2) begin
      n_cmp++; if (ren_q[0] !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_adr0 got %h want ffff", ren_q[0]); end
      n_cmp++; if (ren_q[1] !== 16'h0000) begin n_fail++; $display("FAIL wrap_adr1 got %h want 0000", ren_q[1]); end
    end
    if (rx_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL wrap_byte%0d got %h want %h", i, rx_q[i], exp[i]); end
      end
    end else begin
      n_cmp++; n_fail++; $display("FAIL wrap_nbytes got %0d want %0d", rx_q.size(), 4 + CK_BYTES);
    end
    n_cmp++; if (bus.mem_adr_o !== 16'h0000) begin n_fail++; $display("FAIL wrap_adr_hold got %h want 0000", bus.mem_adr_o); end
    clear_logs();
    do_start(16'h0020, 16'h0000, t);
    wait_done(1000, td);
    n_cmp++; if (td != t + 1 + CK_CYC) begin n_fail++; $display("FAIL empty_done_time got %0d want %0d", td - t, 1 + CK_CYC); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL empty_busy got %b want 0", bus.busy_o); end
    repeat (3) @(negedge clk);
    n_cmp++; if (ren_q.size() != 0) begin n_fail++; $display("FAIL empty_nreads got %0d want 0", ren_q.size()); end
    n_cmp++; if (rx_q.size() != CK_BYTES) begin n_fail++; $display("FAIL empty_nbytes got %0d want %0d", rx_q.size(), CK_BYTES); end
  endtask

  task automatic test_reset_mid_frame();
    int t, td;
    clear_logs();
    mem[16'h0040] = 16'h1111;
    mem[16'h0041] = 16'h2222;
    do_start(16'h0040, 16'h0002, t);
    // Second byte starts at t+3+FRAME; D3 occupies its bit slot 4.
    while (cyc < t + 3 + FRAME + 4 * CPB + 1) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.uart_tx_o !== 1'b0) begin n_fail++; $display("FAIL midrst_d3_level got %b want 0", bus.uart_tx_o); end
    n_cmp++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL midrst_bytes_before got %0d want 1", rx_q.size()); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.uart_tx_o !== 1'b1) begin n_fail++; $display("FAIL midrst_tx got %b want 1", bus.uart_tx_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.mem_adr_o !== 16'h0000) begin n_fail++; $display("FAIL midrst_adr got %h want 0000", bus.mem_adr_o); end
    repeat (100) @(negedge clk);
    n_cmp++; if (bus.uart_tx_o !== 1'b1 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_no_resume got tx=%b busy=%b want tx=1 busy=0", bus.uart_tx_o, bus.busy_o); end
    clear_logs();
    mem[16'h0050] = 16'hC33C;
    do_start(16'h0050, 16'h0001, t);
    wait_done(1000, td);
    n_cmp++; if (td != t + 1 + PER_WORD + CK_CYC) begin n_fail++; $display("FAIL restart_done_time got %0d want %0d", td - t, 1 + PER_WORD + CK_CYC); end
    if (rx_q.size() >= 2) begin
      n_cmp++; if (rx_q[0] !== 8'h3C) begin n_fail++; $display("FAIL restart_byte0 got %h want 3c", rx_q[0]); end
      n_cmp++; if (rx_q[1] !== 8'hC3) begin n_fail++; $display("FAIL restart_byte1 got %h want c3", rx_q[1]); end
      n_cmp++; if (rx_t[0] != t + 3) begin n_fail++; $display("FAIL restart_latency got %0d want 3", rx_t[0] - t); end
    end else begin
      n_cmp++; n_fail++; $display("FAIL restart_nbytes got %0d want %0d", rx_q.size(), 2 + CK_BYTES);
    end
  endtask

  task automatic test_checksum();
    int t, td;
    logic [7:0] exp [0:5];
    exp[0] = 8'h00; exp[1] = 8'h80; exp[2] = 8'h01; exp[3] = 8'h80; exp[4] = 8'h01; exp[5] = 8'h00;
    clear_logs();
    mem[16'h0060] = 16'h8000;
    mem[16'h0061] = 16'h8001;
    do_start(16'h0060, 16'h0002, t);
    wait_done(2000, td);
    n_cmp++; if (td != t + 1 + 2 * PER_WORD + CK_CYC) begin n_fail++; $display("FAIL cksum_done_time got %0d want %0d", td - t, 1 + 2 * PER_WORD + CK_CYC); end
    n_cmp++; if (rx_q.size() != 4 + CK_BYTES) begin n_fail++; $display("FAIL cksum_nbytes got %0d want %0d", rx_q.size(), 4 + CK_BYTES); end
    if (rx_q.size() == 4 + CK_BYTES) begin
      for (int i = 0; i < 4 + CK_BYTES; i++) begin
        n_cmp++; if (rx_q[i] !== exp[i]) begin n_fail++; $display("FAIL cksum_byte%0d got %h want %h", i, rx_q[i], exp[i]); end
      end
    end
    n_cmp++; if (frame_err != 0) begin n_fail++; $display("FAIL cksum_stop_bits got %0d want 0", frame_err); end
  endtask

  initial begin
    bus.start_i = 1'b0;
    bus.base_adr_i = 16'h0000;
    bus.len_i = 16'h0000;
    test_reset();
    test_single_word();
    test_multi_word();
    test_addr_wrap_and_empty();
    test_reset_mid_frame();
    test_checksum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
